// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: parametrised register file with a pending-load
// scoreboard, optional hardwired r0 and optional same-cycle read forwarding.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic                  BUSYWAIT,
    input  logic                  PEND_SET,
    input  logic [ADDR_WIDTH-1:0] PEND_ADDR,
    input  logic                  LOAD_VALID,
    input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
    input  logic [DATA_WIDTH-1:0] LOAD_DATA,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2,
    output logic                  HAZARD1,
    output logic                  HAZARD2,
    output logic [ADDR_WIDTH:0]   PEND_CNT
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [DEPTH-1:0]      pend_nxt;
    logic [CW-1:0]         cnt_nxt;
    logic                  wb_ok;
    logic                  set_ok;
    logic                  ld_hit;
    logic                  ld_ok;

    // Qualify each update source; reset low blocks every update and bypass.
    always_comb begin
        wb_ok  = RESET & WRITE & ~BUSYWAIT
               & ~(ZR && (INADDRESS == '0));
        set_ok = RESET & PEND_SET & ~BUSYWAIT
               & ~(ZR && (PEND_ADDR == '0));
        ld_hit = RESET & LOAD_VALID & pend[LOAD_ADDR];
        ld_ok  = ld_hit & ~(wb_ok && (INADDRESS == LOAD_ADDR));
    end

    // Next pending bits: returns and writebacks clear, a new load re-sets.
    always_comb begin
        pend_nxt = pend;
        if (RESET && LOAD_VALID) pend_nxt[LOAD_ADDR] = 1'b0;
        if (wb_ok) pend_nxt[INADDRESS] = 1'b0;
        if (set_ok) pend_nxt[PEND_ADDR] = 1'b1;
    end

    // Population count of the next pending set, registered with the bits.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
        end
    end

    // Register array: writeback wins over a load return to the same slot.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (ld_ok) regs[LOAD_ADDR] <= LOAD_DATA;
            if (wb_ok) regs[INADDRESS] <= IN;
        end
    end

    // Scoreboard bits and their count.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend     <= '0;
            PEND_CNT <= '0;
        end else begin
            pend     <= pend_nxt;
            PEND_CNT <= cnt_nxt;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] rd_data(
        input logic [ADDR_WIDTH-1:0] a
    );
        logic [DATA_WIDTH-1:0] d;
        d = regs[a];
        if (BP && ld_hit && (a == LOAD_ADDR)) d = LOAD_DATA;
        if (BP && wb_ok && (a == INADDRESS)) d = IN;
        if (ZR && (a == '0)) d = '0;
        return d;
    endfunction

    function automatic logic rd_haz(
        input logic [ADDR_WIDTH-1:0] a
    );
        logic h;
        h = pend[a];
        if (BP && ld_hit && (a == LOAD_ADDR)) h = 1'b0;
        if (BP && wb_ok && (a == INADDRESS)) h = 1'b0;
        if (ZR && (a == '0)) h = 1'b0;
        return h;
    endfunction

    // Combinational read ports with optional forwarding.
    always_comb begin
        OUT1    = rd_data(OUT1ADDRESS);
        OUT2    = rd_data(OUT2ADDRESS);
        HAZARD1 = rd_haz(OUT1ADDRESS);
        HAZARD2 = rd_haz(OUT2ADDRESS);
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed and random stimulus on two configurations
// of reg_file_scoreboard, compared against a rule-level model.
module tb_reg_file_scoreboard;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] in_d;
    logic [3:0]  in_a;
    logic        write;
    logic        busy;
    logic        pset;
    logic [3:0]  paddr;
    logic        lvalid;
    logic [3:0]  laddr;
    logic [15:0] ldata;
    logic [3:0]  o1a;
    logic [3:0]  o2a;

    logic [7:0]  a_o1, a_o2;
    logic        a_h1, a_h2;
    logic [3:0]  a_cnt;
    logic [15:0] b_o1, b_o2;
    logic        b_h1, b_h2;
    logic [4:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    // k=0: 8-bit, 8 regs, no zero reg, bypass. k=1: 16-bit, 16 regs, r0 zero, no bypass.
    logic [15:0] mreg [2][16];
    bit          mpend [2][16];

    always #5 CLK = ~CLK;

    reg_file_scoreboard u_a (
        .CLK(CLK), .RESET(RESET),
        .IN(in_d[7:0]), .INADDRESS(in_a[2:0]),
        .WRITE(write), .BUSYWAIT(busy),
        .PEND_SET(pset), .PEND_ADDR(paddr[2:0]),
        .LOAD_VALID(lvalid), .LOAD_ADDR(laddr[2:0]),
        .LOAD_DATA(ldata[7:0]),
        .OUT1ADDRESS(o1a[2:0]), .OUT2ADDRESS(o2a[2:0]),
        .OUT1(a_o1), .OUT2(a_o2),
        .HAZARD1(a_h1), .HAZARD2(a_h2),
        .PEND_CNT(a_cnt)
    );

    reg_file_scoreboard #(
        .DATA_WIDTH(16), .ADDR_WIDTH(4),
        .ZERO_REG(1), .BYPASS(0)
    ) u_b (
        .CLK(CLK), .RESET(RESET),
        .IN(in_d), .INADDRESS(in_a),
        .WRITE(write), .BUSYWAIT(busy),
        .PEND_SET(pset), .PEND_ADDR(paddr),
        .LOAD_VALID(lvalid), .LOAD_ADDR(laddr),
        .LOAD_DATA(ldata),
        .OUT1ADDRESS(o1a), .OUT2ADDRESS(o2a),
        .OUT1(b_o1), .OUT2(b_o2),
        .HAZARD1(b_h1), .HAZARD2(b_h2),
        .PEND_CNT(b_cnt)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] am(input int k, input logic [3:0] a);
        return (k == 0) ? {1'b0, a[2:0]} : a;
    endfunction

    function automatic logic [15:0] dm(input int k, input logic [15:0] d);
        return (k == 0) ? (d & 16'h00FF) : d;
    endfunction

    function automatic bit zr(input int k);
        return k == 1;
    endfunction

    function automatic bit bp(input int k);
        return k == 0;
    endfunction

    function automatic bit m_we(input int k);
        return RESET && write && !busy && !(zr(k) && am(k, in_a) == 0);
    endfunction

    function automatic bit m_ps(input int k);
        return RESET && pset && !busy && !(zr(k) && am(k, paddr) == 0);
    endfunction

    function automatic bit m_lv(input int k);
        return RESET && lvalid && mpend[k][am(k, laddr)];
    endfunction

    function automatic logic [15:0] m_read(input int k, input logic [3:0] a4);
        logic [3:0] a;
        a = am(k, a4);
        if (zr(k) && a == 0) return 16'h0;
        if (bp(k) && m_we(k) && a == am(k, in_a)) return dm(k, in_d);
        if (bp(k) && m_lv(k) && a == am(k, laddr)) return dm(k, ldata);
        return mreg[k][a];
    endfunction

    function automatic bit m_haz(input int k, input logic [3:0] a4);
        logic [3:0] a;
        a = am(k, a4);
        if (zr(k) && a == 0) return 1'b0;
        if (bp(k) && m_we(k) && a == am(k, in_a)) return 1'b0;
        if (bp(k) && m_lv(k) && a == am(k, laddr)) return 1'b0;
        return mpend[k][a];
    endfunction

    function automatic int m_cnt(input int k);
        int c;
        c = 0;
        for (int i = 0; i < 16; i++) c += int'(mpend[k][i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                mreg[k][i]  = 16'h0;
                mpend[k][i] = 1'b0;
            end
    endtask

    task automatic idle();
        write  = 1'b0;
        busy   = 1'b0;
        pset   = 1'b0;
        lvalid = 1'b0;
    endtask

    // One clock: check both instances mid-cycle, then advance the model.
    task automatic cycle();
        logic [15:0] nr [2][16];
        bit          np [2][16];
        logic [3:0]  wa, la, pa;
        @(negedge CLK);
        #1;
        chk("A_OUT1", a_o1, m_read(0, o1a));
        chk("A_OUT2", a_o2, m_read(0, o2a));
        chk("A_HAZ1", a_h1, m_haz(0, o1a));
        chk("A_HAZ2", a_h2, m_haz(0, o2a));
        chk("A_CNT", a_cnt, m_cnt(0));
        chk("B_OUT1", b_o1, m_read(1, o1a));
        chk("B_OUT2", b_o2, m_read(1, o2a));
        chk("B_HAZ1", b_h1, m_haz(1, o1a));
        chk("B_HAZ2", b_h2, m_haz(1, o2a));
        chk("B_CNT", b_cnt, m_cnt(1));
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                nr[k][i] = mreg[k][i];
                np[k][i] = mpend[k][i];
            end
            wa = am(k, in_a);
            la = am(k, laddr);
            pa = am(k, paddr);
            if (m_lv(k) && !(m_we(k) && wa == la)) nr[k][la] = dm(k, ldata);
            if (m_we(k)) nr[k][wa] = dm(k, in_d);
            if (RESET && lvalid) np[k][la] = 1'b0;
            if (m_we(k)) np[k][wa] = 1'b0;
            if (m_ps(k)) np[k][pa] = 1'b1;
        end
        @(posedge CLK);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                mreg[k][i]  = nr[k][i];
                mpend[k][i] = np[k][i];
            end
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        write = 1'b1;
        in_a  = a;
        in_d  = d;
    endtask

    task automatic do_pset(input logic [3:0] a);
        pset  = 1'b1;
        paddr = a;
    endtask

    task automatic do_load(input logic [3:0] a, input logic [15:0] d);
        lvalid = 1'b1;
        laddr  = a;
        ldata  = d;
    endtask

    initial begin
        model_clear();
        RESET = 1'b0;
        do_write(4'd3, 16'h1234);
        do_pset(4'd3);
        busy   = 1'b0;
        lvalid = 1'b0;
        laddr  = 4'd0;
        ldata  = 16'h0;
        o1a    = 4'd3;
        o2a    = 4'd3;
        repeat (2) @(posedge CLK);
        #1;
        chk("RST_A_OUT1", a_o1, 0);
        chk("RST_A_HAZ1", a_h1, 0);
        chk("RST_A_CNT", a_cnt, 0);
        chk("RST_B_OUT1", b_o1, 0);
        chk("RST_B_CNT", b_cnt, 0);
        idle();
        RESET = 1'b1;

        // Reset mid-operation.
        do_write(4'd3, 16'h005A);
        cycle();
        idle();
        do_pset(4'd4);
        cycle();
        idle();
        o1a = 4'd3;
        o2a = 4'd4;
        #1;
        chk("PRE_RST_OUT1", a_o1, 8'h5A);
        chk("PRE_RST_HAZ2", a_h2, 1);
        RESET = 1'b0;
        #1;
        chk("MID_RST_OUT1", a_o1, 0);
        chk("MID_RST_CNT", a_cnt, 0);
        chk("MID_RST_B_OUT1", b_o1, 0);
        chk("MID_RST_B_CNT", b_cnt, 0);
        o1a = 4'd4;
        #1;
        chk("MID_RST_HAZ1", a_h1, 0);
        model_clear();
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Load scoreboard with forwarding.
        do_pset(4'd2);
        cycle();
        idle();
        o1a = 4'd2;
        #1;
        chk("LD_HAZ_SET", a_h1, 1);
        chk("LD_CNT_1", a_cnt, 1);
        cycle();
        do_load(4'd2, 16'h007F);
        #1;
        chk("LD_FWD_OUT1", a_o1, 8'h7F);
        chk("LD_FWD_HAZ1", a_h1, 0);
        cycle();
        idle();
        #1;
        chk("LD_CNT_0", a_cnt, 0);
        chk("LD_ARRAY", a_o1, 8'h7F);

        // WAW and stale return.
        do_pset(4'd5);
        cycle();
        idle();
        #1;
        chk("WAW_CNT_1", a_cnt, 1);
        do_write(4'd5, 16'h0011);
        cycle();
        idle();
        #1;
        chk("WAW_CNT_0", a_cnt, 0);
        do_load(4'd5, 16'h0099);
        cycle();
        idle();
        o1a = 4'd5;
        #1;
        chk("STALE_OUT1", a_o1, 8'h11);
        chk("STALE_CNT", a_cnt, 0);

        // Collisions on r6.
        do_pset(4'd6);
        cycle();
        idle();
        do_write(4'd6, 16'h0022);
        do_load(4'd6, 16'h0033);
        cycle();
        idle();
        o1a = 4'd6;
        #1;
        chk("COL_WB_OUT1", a_o1, 8'h22);
        chk("COL_WB_HAZ1", a_h1, 0);
        chk("COL_WB_CNT", a_cnt, 0);
        do_pset(4'd6);
        cycle();
        do_load(4'd6, 16'h0044);
        cycle();
        idle();
        #1;
        chk("COL_LD_OUT1", a_o1, 8'h44);
        chk("COL_LD_HAZ1", a_h1, 1);
        chk("COL_LD_CNT", a_cnt, 1);
        do_write(4'd6, 16'h0055);
        do_pset(4'd6);
        cycle();
        idle();
        #1;
        chk("COL_PS_OUT1", a_o1, 8'h55);
        chk("COL_PS_HAZ1", a_h1, 1);
        chk("COL_PS_CNT", a_cnt, 1);

        // BUSYWAIT gates writes and pend-sets, not returns.
        do_pset(4'd7);
        cycle();
        idle();
        busy = 1'b1;
        do_write(4'd1, 16'h000F);
        do_pset(4'd1);
        do_load(4'd7, 16'h00A5);
        cycle();
        idle();
        o1a = 4'd1;
        o2a = 4'd7;
        #1;
        chk("BUSY_OUT1", a_o1, 0);
        chk("BUSY_HAZ1", a_h1, 0);
        chk("BUSY_LD_OUT2", a_o2, 8'hA5);
        chk("BUSY_LD_HAZ2", a_h2, 0);
        chk("BUSY_CNT", a_cnt, 1);

        // Wide config: hardwired r0, no forwarding.
        do_write(4'd0, 16'hBEEF);
        o1a = 4'd0;
        cycle();
        idle();
        #1;
        chk("B_R0_OUT1", b_o1, 0);
        do_write(4'd15, 16'hBEEF);
        o1a = 4'd15;
        #1;
        chk("B_NOBYP_OUT1", b_o1, 0);
        cycle();
        idle();
        #1;
        chk("B_R15_OUT1", b_o1, 16'hBEEF);
        for (int a = 1; a < 16; a++) begin
            do_pset(4'(a));
            cycle();
            idle();
        end
        #1;
        chk("B_CNT_ALL", b_cnt, 15);
        do_pset(4'd0);
        o1a = 4'd0;
        cycle();
        idle();
        #1;
        chk("B_CNT_R0", b_cnt, 15);
        chk("B_R0_HAZ1", b_h1, 0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            in_d   = 16'($urandom);
            in_a   = 4'($urandom);
            write  = ($urandom_range(0, 2) == 0);
            busy   = ($urandom_range(0, 3) == 0);
            pset   = ($urandom_range(0, 2) == 0);
            paddr  = 4'($urandom);
            lvalid = ($urandom_range(0, 1) == 0);
            laddr  = 4'($urandom);
            ldata  = 16'($urandom);
            o1a    = 4'($urandom);
            o2a    = 4'($urandom);
            if ($urandom_range(0, 2) == 0) o1a = laddr;
            if ($urandom_range(0, 2) == 0) o2a = in_a;
            if ($urandom_range(0, 4) == 0) laddr = in_a;
            cycle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
